// File: rtl/period_meter.sv
// rtl/period_meter.sv - rising-edge period meter for one asynchronous input
//
// Measures the number of clk_clk cycles between consecutive synchronized
// rising edges of sig_in and publishes the count for a PIO input.
//
// Ports:
//   clk_clk      in   system clock, single domain
//   reset_reset  in   asynchronous active-high reset
//   sig_in       in   asynchronous signal under measurement
//   enable       in   measurement enable (synchronous level)
//   period_out   out  last published period in clk_clk cycles
//   period_valid out  one-cycle pulse, the cycle after period_out updates
//   overflow     out  last published period saturated without an edge
//   armed        out  FSM is in ARM or MEASURE
//
// Build option: define PERIOD_METER_DEGLITCH_EN to insert a 3-sample
// majority filter ahead of the edge detector (suppresses 1-clock pulses and
// gaps, adds 2 cycles of latency).

module period_meter #(
  parameter int WIDTH       = 28,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic             sig_in,
  input  logic             enable,
  output logic [WIDTH-1:0] period_out,
  output logic             period_valid,
  output logic             overflow,
  output logic             armed
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;
  logic                   s_filt;
  logic                   s_prev;
  logic                   edge_det;
  logic [1:0]             state;
  logic [WIDTH-1:0]       cnt;
  logic                   publish;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
    end
  end

  assign s_sync = sync_q[SYNC_STAGES-1];

`ifdef PERIOD_METER_DEGLITCH_EN
  logic [1:0] dly_q;
  logic       filt_q;

  // Majority of three consecutive samples; registering the vote gives a
  // uniform 2-cycle delay for clean transitions.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      dly_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      dly_q  <= {dly_q[0], s_sync};
      filt_q <= (s_sync & dly_q[0]) | (s_sync & dly_q[1]) | (dly_q[0] & dly_q[1]);
    end
  end

  assign s_filt = filt_q;
`else
  assign s_filt = s_sync;
`endif

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      s_prev <= 1'b0;
    end else begin
      s_prev <= s_filt;
    end
  end

  assign edge_det = s_filt & ~s_prev;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      period_out   <= '0;
      overflow     <= 1'b0;
      publish      <= 1'b0;
      period_valid <= 1'b0;
    end else begin
      publish      <= 1'b0;
      // Valid trails the result registers by one cycle so period_out and
      // overflow are already stable when the pulse is seen.
      period_valid <= publish;
      if (!enable) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            cnt   <= '0;
            state <= ST_ARM;
          end
          ST_ARM: begin
            if (edge_det) begin
              cnt   <= CNT_ONE;
              state <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            // Edge is checked first so a coincident edge publishes all-ones
            // as a normal result with overflow clear.
            if (edge_det) begin
              period_out <= cnt;
              overflow   <= 1'b0;
              publish    <= 1'b1;
              cnt        <= CNT_ONE;
            end else if (cnt == CNT_MAX) begin
              period_out <= CNT_MAX;
              overflow   <= 1'b1;
              publish    <= 1'b1;
              cnt        <= '0;
              state      <= ST_ARM;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign armed = (state == ST_ARM) || (state == ST_MEASURE);

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - directed self-checking bench for period_meter

module tb_period_meter;

`ifdef PERIOD_METER_DEGLITCH_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic sig_m, en_m, sig_s, en_s;

  logic [27:0] period_m;
  logic        valid_m, ovf_m, armed_m;
  logic [7:0]  period_s;
  logic        valid_s, ovf_s, armed_s;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  int vcnt_m = 0, vsum_m = 0, vcyc_m = 0;
  int vcnt_s = 0, vsum_s = 0, vcyc_s = 0;
  int snap_cnt, snap_sum, t_edge;

  always #5 clk = ~clk;

  period_meter u_main (
    .clk_clk      (clk),
    .reset_reset  (rst),
    .sig_in       (sig_m),
    .enable       (en_m),
    .period_out   (period_m),
    .period_valid (valid_m),
    .overflow     (ovf_m),
    .armed        (armed_m)
  );

  period_meter #(.WIDTH(8)) u_small (
    .clk_clk      (clk),
    .reset_reset  (rst),
    .sig_in       (sig_s),
    .enable       (en_s),
    .period_out   (period_s),
    .period_valid (valid_s),
    .overflow     (ovf_s),
    .armed        (armed_s)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_m === 1'b1) begin
      vcnt_m <= vcnt_m + 1;
      vsum_m <= vsum_m + int'(period_m);
      vcyc_m <= cyc;
    end
    if (valid_s === 1'b1) begin
      vcnt_s <= vcnt_s + 1;
      vsum_s <= vsum_s + int'(period_s);
      vcyc_s <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_m(input logic v, input int n);
    sig_m = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_s(input logic v, input int n);
    sig_s = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en_m = 1'b0; en_s = 1'b0; sig_m = 1'b0; sig_s = 1'b0;

    // Reset with sig_in toggling
    for (int i = 0; i < 6; i++) begin
      drive_m(~sig_m, 1);
      sig_s = ~sig_s;
    end
    check("rst_period", {4'd0, period_m}, 32'd0);
    check("rst_valid", {31'd0, valid_m}, 32'd0);
    check("rst_overflow", {31'd0, ovf_m}, 32'd0);
    check("rst_armed", {31'd0, armed_m}, 32'd0);

    // Release with enable low: nothing happens
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      drive_m(~sig_m, 1);
      sig_s = ~sig_s;
    end
    sig_s = 1'b0;
    drive_m(1'b0, 3);
    check("idle_pulses", vcnt_m, 0);
    check("idle_armed", {31'd0, armed_m}, 32'd0);
    check("idle_period", {4'd0, period_m}, 32'd0);
    check("idle_small_pulses", vcnt_s, 0);

    // Square wave 10 high / 10 low
    en_m = 1'b1;
    drive_m(1'b0, 1);
    check("armed_rise", {31'd0, armed_m}, 32'd1);
    drive_m(1'b0, 2);
    snap_cnt = vcnt_m; snap_sum = vsum_m;
    drive_m(1'b1, 10); drive_m(1'b0, 10);
    check("first_edge_arms_only", vcnt_m - snap_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      drive_m(1'b1, 10); drive_m(1'b0, 10);
    end
    t_edge = cyc + 1;
    drive_m(1'b1, 10); drive_m(1'b0, 10);
    check("sq_pulses", vcnt_m - snap_cnt, 4);
    check("sq_sum", vsum_m - snap_sum, 80);
    check("sq_period", {4'd0, period_m}, 32'd20);
    check("sq_overflow", {31'd0, ovf_m}, 32'd0);
    check("sq_latency", vcyc_m - t_edge, 3 + EXTRA);

    // Disable mid-measurement
    drive_m(1'b1, 10); drive_m(1'b0, 5);
    en_m = 1'b0;
    drive_m(1'b0, 1);
    check("armed_fall", {31'd0, armed_m}, 32'd0);
    drive_m(1'b0, 4);
    snap_cnt = vcnt_m;
    for (int i = 0; i < 3; i++) begin
      drive_m(1'b1, 10); drive_m(1'b0, 10);
    end
    check("dis_no_pulse", vcnt_m - snap_cnt, 0);
    check("dis_period_hold", {4'd0, period_m}, 32'd20);
    check("dis_armed", {31'd0, armed_m}, 32'd0);
    en_m = 1'b1;
    drive_m(1'b0, 3);
    check("reen_armed", {31'd0, armed_m}, 32'd1);
    snap_cnt = vcnt_m;
    drive_m(1'b1, 8); drive_m(1'b0, 8);
    check("reen_first_arms", vcnt_m - snap_cnt, 0);
    drive_m(1'b1, 8); drive_m(1'b0, 8);
    check("reen_pulses", vcnt_m - snap_cnt, 1);
    check("reen_period", {4'd0, period_m}, 32'd16);

    // Toggle every clock -> period 2 (filtered out entirely with deglitch)
    en_m = 1'b0; drive_m(1'b0, 2);
    en_m = 1'b1; drive_m(1'b0, 2);
    snap_cnt = vcnt_m; snap_sum = vsum_m;
    for (int i = 0; i < 20; i++) begin
      drive_m(1'b1, 1); drive_m(1'b0, 1);
    end
    drive_m(1'b0, 8);
    check("tog_pulses", vcnt_m - snap_cnt, (EXTRA == 0) ? 19 : 0);
    check("tog_sum", vsum_m - snap_sum, (EXTRA == 0) ? 38 : 0);
    check("tog_period", {4'd0, period_m}, (EXTRA == 0) ? 32'd2 : 32'd16);

    // 20-clock period with a 1-clock glitch in the low phase
    en_m = 1'b0; drive_m(1'b0, 2);
    en_m = 1'b1; drive_m(1'b0, 2);
    snap_cnt = vcnt_m; snap_sum = vsum_m;
    for (int i = 0; i < 3; i++) begin
      drive_m(1'b1, 10); drive_m(1'b0, 4); drive_m(1'b1, 1); drive_m(1'b0, 5);
    end
    drive_m(1'b1, 10); drive_m(1'b0, 10);
    check("gl_pulses", vcnt_m - snap_cnt, (EXTRA == 0) ? 6 : 3);
    check("gl_sum", vsum_m - snap_sum, 60);
    check("gl_period", {4'd0, period_m}, (EXTRA == 0) ? 32'd6 : 32'd20);
    en_m = 1'b0;

    // WIDTH=8 saturation
    en_s = 1'b1;
    drive_s(1'b0, 3);
    snap_cnt = vcnt_s;
    t_edge = cyc + 1;
    drive_s(1'b1, 5); drive_s(1'b0, 300);
    check("ovf_pulses", vcnt_s - snap_cnt, 1);
    check("ovf_period", {24'd0, period_s}, 32'd255);
    check("ovf_flag", {31'd0, ovf_s}, 32'd1);
    check("ovf_back_to_arm", {31'd0, armed_s}, 32'd1);
    check("ovf_latency", vcyc_s - t_edge, 258 + EXTRA);
    snap_cnt = vcnt_s;
    drive_s(1'b1, 5); drive_s(1'b0, 45);
    drive_s(1'b1, 5); drive_s(1'b0, 45);
    check("post_ovf_pulses", vcnt_s - snap_cnt, 1);
    check("post_ovf_period", {24'd0, period_s}, 32'd50);
    check("post_ovf_flag", {31'd0, ovf_s}, 32'd0);

    // Asynchronous reset mid-measurement
    drive_s(1'b1, 5); drive_s(1'b0, 10);
    rst = 1'b1;
    #1;
    check("arst_period", {24'd0, period_s}, 32'd0);
    check("arst_armed", {31'd0, armed_s}, 32'd0);
    check("arst_main_period", {4'd0, period_m}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/period_meter.md
# period_meter

Fabric-side measurement channel that runs opposite to the software-programmed period outputs. It does not generate a waveform from a Nios-written period. It measures the period of an external digital signal in system clock cycles and publishes the result as a 28-bit value suitable for a Nios PIO input. One instance per monitored signal sits between the board pin and the Qsys system.

## Interface
Parameters:
- WIDTH, 28: width of the period counter and result; the saturation value is 2^WIDTH-1.
- SYNC_STAGES, 2: number of metastability flops on sig_in; legal values are 2 or 3.

Ports:
- clk_clk, input, 1: system clock; all logic is in this single domain.
- reset_reset, input, 1: asynchronous, active-high reset.
- sig_in, input, 1: asynchronous signal being measured; only rising edges are counted.
- enable, input, 1: measurement enable, synchronous level.
- period_out, output, WIDTH: last published period in clk_clk cycles.
- period_valid, output, 1: one-cycle pulse, asserted in the cycle after period_out updates.
- overflow, output, 1: high when the last published period saturated with no edge.
- armed, output, 1: high when the FSM is in ARM or MEASURE.

## Operation
- Synchronizer: SYNC_STAGES flops produce s_sync. A one-flop delay produces s_prev. The edge condition is edge = s_sync & ~s_prev.
- FSM states are IDLE, ARM, and MEASURE.
  - IDLE: cnt = 0. Go to ARM when enable=1. An edge in the same cycle is ignored.
  - ARM: wait for edge. On edge, set cnt <= 1 and go to MEASURE.
  - MEASURE: each cycle, cnt <= cnt+1.
    - On edge: period_out <= cnt, overflow <= 0, pulse valid, cnt <= 1, stay in MEASURE.
    - When cnt == 2^WIDTH-1 with no edge: period_out <= all-ones, overflow <= 1, pulse valid, cnt <= 0, go to ARM.
    - When edge and saturation occur in the same cycle, the edge wins. This gives a normal publish of all-ones with overflow=0.
  - enable=0 in any state: go to IDLE on the next clock and clear cnt. period_out and overflow hold their values.
- The result counts cycles between consecutive synchronized rising edges. An input with one rising edge every N clocks reports N.
- The minimum reportable period is 2 (sig_in toggling every clock). Period 0 or 1 is never published.
- Counter arithmetic is unsigned at WIDTH bits. The counter never wraps; it saturates and then takes the overflow path.
- The first edge after entering ARM only starts timing. No result is published for it.

## Timing
- Reset values:
  - period_out = 0, period_valid = 0, overflow = 0, armed = 0.
  - FSM = IDLE, cnt = 0, synchronizer flops = 0.
- Latency from the clock that first samples sig_in high to the period_valid pulse is SYNC_STAGES+1 cycles. That is 3 with the defaults, plus 2 with deglitch.
- period_out and overflow change only in the cycle before the period_valid pulse. Between pulses they are stable.
- No backpressure exists: a result not consumed before the next pulse is overwritten.
- armed rises one cycle after enable is sampled high. It falls one cycle after enable is sampled low.
- Reset asserted mid-measurement immediately forces every reset value. Deassertion starts in IDLE.

## Configuration
- PERIOD_METER_DEGLITCH_EN defined:
  - A 3-sample majority filter (s_sync plus two further delay flops) is inserted between the synchronizer and the edge detector.
  - Pulses or gaps of 1 clock are suppressed.
  - Latency grows by 2 cycles.
  - Measured periods are unchanged for clean inputs with high and low times of at least 2 clocks.
- Macro undefined: no filter and base latency. A 1-clock glitch counts as an edge.

## Test plan
- Reset with sig_in toggling, then release with enable=0 -> all outputs stay 0 and armed=0 indefinitely.
- enable=1 with a square wave of 10 high / 10 low clocks:
  - First edge only arms.
  - From the second edge on, every rising edge gives period_out=20, overflow=0 and one period_valid pulse, 3 clocks after the edge is sampled.
- WIDTH=8 with a single edge, then sig_in held low -> 255 cycles after the arming edge, period_out=255, overflow=1 and one valid pulse. The FSM returns to ARM.
  - Next two edges 50 clocks apart give period_out=50 with overflow cleared.
- sig_in toggling every clock -> period_out=2 on every valid pulse.
- Deassert enable mid-MEASURE, then reassert:
  - No pulse while disabled; period_out holds its last value.
  - After reassertion, the first edge only arms.
- PERIOD_METER_DEGLITCH_EN defined, 20-clock period with a 1-clock high glitch inserted mid-low-phase -> reports only period_out=20. Latency is 5 clocks.
  - Without the macro, the same stimulus yields two shorter periods summing to 20.
